// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM for the multicycle RV32I core
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] Op,
    input  logic       BranchTaken,
    input  logic       MemReady,
    output logic       MemReq,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic [1:0] PCSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ResultSrc,
    output logic       RegWrite,
    output logic       InstrRetired,
    output logic       IllegalOp,
    output logic [3:0] State
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER,
        EXECUTEI, ALUWB, BRANCH, JAL, JALR, LUI
    } state_t;
    state_t state_q, state_d, st;
    logic mreq, mwr, irw, pcw, rfw, ret, ill;
    always_ff @(posedge clk) state_q <= rst ? FETCH : state_d;
    always_comb begin
        st = rst ? FETCH : state_q;
        state_d = FETCH;
        mreq = 1'b0;
        AdrSrc = 1'b0;
        mwr = 1'b0;
        irw = 1'b0;
        pcw = 1'b0;
        PCSrc = 2'b00;
        ALUSrcA = 2'b00;
        ALUSrcB = 2'b00;
        ALUOp = 2'b00;
        ResultSrc = 2'b00;
        rfw = 1'b0;
        ill = 1'b0;
        case (st)
            FETCH: begin
                mreq = 1'b1;
                irw = MemReady;
                pcw = MemReady;
                state_d = MemReady ? DECODE : FETCH;
            end
            DECODE: begin
                case (Op)
                    7'b0000011, 7'b0100011: state_d = MEMADR;
                    7'b0110011: state_d = EXECUTER;
                    7'b0010011: state_d = EXECUTEI;
                    7'b1100011: state_d = BRANCH;
                    7'b1101111: state_d = JAL;
                    7'b1100111: state_d = JALR;
                    7'b0110111: state_d = LUI;
                    default: ill = 1'b1;
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (Op == 7'b0000011) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                mreq = 1'b1;
                AdrSrc = 1'b1;
                state_d = MemReady ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                rfw = 1'b1;
            end
            MEMWRITE: begin
                mreq = 1'b1;
                AdrSrc = 1'b1;
                mwr = 1'b1;
                state_d = MemReady ? FETCH : MEMWRITE;
            end
            EXECUTER, EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = (st == EXECUTEI) ? 2'b01 : 2'b00;
                ALUOp = 2'b10;
                state_d = ALUWB;
            end
            ALUWB: rfw = 1'b1;
            BRANCH: begin
                ALUSrcA = 2'b10;
                ALUOp = 2'b01;
                PCSrc = 2'b10;
                pcw = BranchTaken;
            end
            JAL, JALR: begin
                ResultSrc = 2'b10;
                rfw = 1'b1;
                ALUSrcA = (st == JALR) ? 2'b10 : 2'b01;
                ALUSrcB = 2'b01;
                PCSrc = 2'b01;
                pcw = 1'b1;
            end
            LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
                rfw = 1'b1;
            end
            default: state_d = FETCH;
        endcase
        ret = (state_d == FETCH) && (st != FETCH) && !ill;
    end
    assign MemReq = mreq & ~rst;
    assign MemWrite = mwr & ~rst;
    assign IRWrite = irw & ~rst;
    assign PCWrite = pcw & ~rst;
    assign RegWrite = rfw & ~rst;
    assign InstrRetired = ret & ~rst;
    assign IllegalOp = ill & ~rst;
    assign State = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench replaying per-cycle expected control words
module tb_multicycle_ctrl;
    logic clk = 1'b0, rst, BranchTaken, MemReady;
    logic [6:0] Op;
    logic MemReq, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, InstrRetired, IllegalOp;
    logic [1:0] PCSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
    logic [3:0] State;
    logic [21:0] obs;
    int n_chk = 0, n_fail = 0;
    string tag;
    typedef struct packed {
        logic mr;
        logic bt;
        logic [21:0] exp;
    } ent_t;
    ent_t sb[$];

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .Op(Op), .BranchTaken(BranchTaken), .MemReady(MemReady),
        .MemReq(MemReq), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .ResultSrc(ResultSrc), .RegWrite(RegWrite),
        .InstrRetired(InstrRetired), .IllegalOp(IllegalOp), .State(State)
    );

    always #5 clk = ~clk;
    assign obs = {State, MemReq, AdrSrc, MemWrite, IRWrite, PCWrite, PCSrc, ALUSrcA,
                  ALUSrcB, ALUOp, ResultSrc, RegWrite, InstrRetired, IllegalOp};

    task automatic check(input string t, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", t, got, exp);
        end
    endtask

    function automatic logic [21:0] mk(input logic [3:0] s, input logic mq, ad, mw, ir, pw,
                                       input logic [1:0] ps, a, b, o, r,
                                       input logic rw, rt, il);
        return {s, mq, ad, mw, ir, pw, ps, a, b, o, r, rw, rt, il};
    endfunction

    task automatic add(input logic mr, input logic bt, input logic [21:0] e);
        sb.push_back('{mr, bt, e});
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic gen(input logic [6:0] op, input logic bt, input int fw, input int mw);
        for (int i = 0; i < fw; i++) add(0, bt, mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(1, bt, mk(0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        case (op)
            7'b0000011, 7'b0100011: add(rnd(), bt, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            7'b0110011, 7'b0010011, 7'b1100011: add(rnd(), bt, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            7'b1101111, 7'b1100111, 7'b0110111: add(rnd(), bt, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            default: add(rnd(), bt, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        endcase
        case (op)
            7'b0000011: begin
                add(rnd(), bt, mk(2, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0));
                for (int i = 0; i < mw; i++) add(0, bt, mk(3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                add(1, bt, mk(3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                add(rnd(), bt, mk(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0));
            end
            7'b0100011: begin
                add(rnd(), bt, mk(2, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0));
                for (int i = 0; i < mw; i++) add(0, bt, mk(5, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                add(1, bt, mk(5, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
            end
            7'b0110011, 7'b0010011: begin
                add(rnd(), bt, mk(op[5] ? 6 : 7, 0, 0, 0, 0, 0, 0, 2, op[5] ? 0 : 1, 2, 0, 0, 0, 0));
                add(rnd(), bt, mk(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
            end
            7'b1100011: add(rnd(), bt, mk(9, 0, 0, 0, 0, bt, 2, 2, 0, 1, 0, 0, 1, 0));
            7'b1101111: add(rnd(), bt, mk(10, 0, 0, 0, 0, 1, 1, 1, 1, 0, 2, 1, 1, 0));
            7'b1100111: add(rnd(), bt, mk(11, 0, 0, 0, 0, 1, 1, 2, 1, 0, 2, 1, 1, 0));
            7'b0110111: add(rnd(), bt, mk(12, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 1, 1, 0));
            default: ;
        endcase
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n && sb.size() > 0; i++) begin
            ent_t e = sb.pop_front();
            MemReady = e.mr;
            BranchTaken = e.bt;
            @(negedge clk);
            check(tag, 32'(obs), 32'(e.exp));
            @(posedge clk);
            #1;
        end
        sb.delete();
    endtask

    task automatic instr(input string t, input logic [6:0] op, input logic bt, input int fw, input int mw);
        tag = t;
        Op = op;
        gen(op, bt, fw, mw);
        drain(1000);
    endtask

    task automatic do_reset(input string t);
        rst = 1'b1;
        MemReady = 1'b1;
        #1;
        check({t, "_rst0"}, 32'(obs[17:0]), 32'd0);
        @(posedge clk);
        #1;
        check({t, "_rst1"}, 32'(obs), 32'd0);
        @(posedge clk);
        #1;
        check({t, "_rst2"}, 32'(obs), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        Op = 7'd0;
        BranchTaken = 1'b0;
        MemReady = 1'b0;
        do_reset("init");
        instr("rtype", 7'b0110011, 1'b0, 0, 0);
        instr("load_wait", 7'b0000011, 1'b0, 0, 2);
        instr("store", 7'b0100011, 1'b1, 1, 1);
        instr("itype", 7'b0010011, 1'b0, 2, 0);
        instr("br_nt", 7'b1100011, 1'b0, 0, 0);
        instr("br_t", 7'b1100011, 1'b1, 0, 0);
        instr("jal", 7'b1101111, 1'b0, 0, 0);
        instr("jalr", 7'b1100111, 1'b1, 1, 0);
        instr("lui", 7'b0110111, 1'b0, 0, 0);
        instr("illegal_ff", 7'b1111111, 1'b0, 0, 0);
        instr("illegal_00", 7'b0000000, 1'b1, 1, 0);
        instr("load_fast", 7'b0000011, 1'b0, 0, 0);
        instr("store_fast", 7'b0100011, 1'b0, 0, 0);
        tag = "mid_rst";
        Op = 7'b0110011;
        gen(Op, 1'b0, 0, 0);
        drain(3);
        do_reset("mid");
        instr("post_rst", 7'b0010011, 1'b0, 0, 0);
        @(negedge clk);
        check("final_state", 32'(State), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
